// File: rtl/jedro_1_writeback.sv
// Writeback stage feeding register-file write port C: LSU-priority arbitration, ALU skid buffer with starvation guard.
// Optional JEDRO_1_WB_BYPASS_EN exposes the registered write and the skid entry for decode-stage forwarding.
module jedro_1_writeback #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alu_valid_i,
  output logic                      alu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [2:0]                lsu_funct3_i,
  input  logic [1:0]                lsu_offset_i,
  input  logic [DATA_WIDTH-1:0]     lsu_rdata_i,
  output logic [REG_ADDR_WIDTH-1:0] wpc_addr_o,
  output logic [DATA_WIDTH-1:0]     wpc_data_o,
  output logic                      wpc_we_o,
`ifdef JEDRO_1_WB_BYPASS_EN
  output logic                      byp_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] byp_addr_o,
  output logic [DATA_WIDTH-1:0]     byp_data_o,
  output logic                      byp_skid_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] byp_skid_addr_o,
  output logic [DATA_WIDTH-1:0]     byp_skid_data_o,
`endif
  output logic                      load_err_o
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic                      r_alu_ready;
  logic                      r_skid_full;
  logic [REG_ADDR_WIDTH-1:0] r_skid_rd;
  logic [DATA_WIDTH-1:0]     r_skid_data;
  logic [3:0]                r_starve_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_wpc_addr;
  logic [DATA_WIDTH-1:0]     r_wpc_data;
  logic                      r_wpc_we;
  logic                      r_load_err;

  logic                      w_alu_hs;
  logic                      w_cand_valid;
  logic [REG_ADDR_WIDTH-1:0] w_cand_rd;
  logic [DATA_WIDTH-1:0]     w_cand_data;
  logic                      w_force;
  logic                      w_lsu_win;
  logic                      w_alu_win;
  logic                      w_skid_load;
  logic                      w_skid_full_nxt;
  logic [DATA_WIDTH-1:0]     w_shifted;
  logic [DATA_WIDTH-1:0]     w_load_data;
  logic                      w_load_err;

  // The skid entry always outranks a fresh ALU beat; ready is low while it is occupied.
  assign w_alu_hs     = alu_valid_i & r_alu_ready;
  assign w_cand_valid = r_skid_full | w_alu_hs;
  assign w_cand_rd    = r_skid_full ? r_skid_rd   : alu_rd_i;
  assign w_cand_data  = r_skid_full ? r_skid_data : alu_data_i;

  assign w_force   = w_cand_valid & (r_starve_cnt == LP_LIMIT);
  assign w_lsu_win = lsu_valid_i & ~w_force;
  assign w_alu_win = w_cand_valid & ~w_lsu_win;

  assign w_skid_load     = ~r_skid_full & w_alu_hs & ~w_alu_win;
  assign w_skid_full_nxt = w_skid_load | (r_skid_full & ~w_alu_win);

  assign alu_ready_o = r_alu_ready;
  assign lsu_ready_o = ~w_force;

  assign w_shifted = lsu_rdata_i >> {lsu_offset_i, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    w_load_err  = 1'b0;
    case (lsu_funct3_i)
      3'b000: w_load_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001: begin
        w_load_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
        w_load_err  = lsu_offset_i[0];
      end
      3'b010: w_load_err = |lsu_offset_i;
      3'b100: w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      3'b101: begin
        w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
        w_load_err  = lsu_offset_i[0];
      end
      default: w_load_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alu_ready  <= 1'b0;
      r_skid_full  <= 1'b0;
      r_skid_rd    <= '0;
      r_skid_data  <= '0;
      r_starve_cnt <= '0;
      r_wpc_addr   <= '0;
      r_wpc_data   <= '0;
      r_wpc_we     <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_alu_ready <= ~w_skid_full_nxt;
      r_skid_full <= w_skid_full_nxt;
      if (w_skid_load) begin
        r_skid_rd   <= alu_rd_i;
        r_skid_data <= alu_data_i;
      end

      if (w_cand_valid && !w_alu_win) begin
        if (r_starve_cnt != LP_LIMIT) r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= '0;
      end

      // Faulting loads are consumed but leave the last written address/data untouched.
      r_wpc_we   <= 1'b0;
      r_load_err <= 1'b0;
      if (w_lsu_win) begin
        r_load_err <= w_load_err;
        if (!w_load_err) begin
          r_wpc_addr <= lsu_rd_i;
          r_wpc_data <= w_load_data;
          r_wpc_we   <= (lsu_rd_i != '0);
        end
      end else if (w_alu_win) begin
        r_wpc_addr <= w_cand_rd;
        r_wpc_data <= w_cand_data;
        r_wpc_we   <= (w_cand_rd != '0);
      end
    end
  end

  assign wpc_addr_o = r_wpc_addr;
  assign wpc_data_o = r_wpc_data;
  assign wpc_we_o   = r_wpc_we;
  assign load_err_o = r_load_err;

`ifdef JEDRO_1_WB_BYPASS_EN
  assign byp_valid_o      = r_wpc_we;
  assign byp_addr_o       = r_wpc_addr;
  assign byp_data_o       = r_wpc_data;
  assign byp_skid_valid_o = r_skid_full & (r_skid_rd != '0);
  assign byp_skid_addr_o  = r_skid_full ? r_skid_rd   : '0;
  assign byp_skid_data_o  = r_skid_full ? r_skid_data : '0;
`endif

endmodule

// File: tb/tb_jedro_1_writeback.sv
// Bench for jedro_1_writeback: vector table, directed multi-cycle sequences, randomized run against a reference model.
module tb_jedro_1_writeback;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [2:0]  lsu_funct3 = '0;
  logic [1:0]  lsu_offset = '0;
  logic [31:0] lsu_rdata = '0;
  logic [4:0]  wpc_addr;
  logic [31:0] wpc_data;
  logic        wpc_we;
  logic        load_err;
`ifdef JEDRO_1_WB_BYPASS_EN
  logic        byp_valid, byp_skid_valid;
  logic [4:0]  byp_addr, byp_skid_addr;
  logic [31:0] byp_data, byp_skid_data;
`endif

  int n_total = 0;
  int n_pass  = 0;

  jedro_1_writeback #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd),
    .lsu_funct3_i(lsu_funct3), .lsu_offset_i(lsu_offset), .lsu_rdata_i(lsu_rdata),
    .wpc_addr_o(wpc_addr), .wpc_data_o(wpc_data), .wpc_we_o(wpc_we),
`ifdef JEDRO_1_WB_BYPASS_EN
    .byp_valid_o(byp_valid), .byp_addr_o(byp_addr), .byp_data_o(byp_data),
    .byp_skid_valid_o(byp_skid_valid), .byp_skid_addr_o(byp_skid_addr), .byp_skid_data_o(byp_skid_data),
`endif
    .load_err_o(load_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_wr(input string name, input logic we, input logic err,
                        input logic [4:0] addr, input logic [31:0] data);
    chk({name, ".we"}, 32'(wpc_we), 32'(we));
    chk({name, ".err"}, 32'(load_err), 32'(err));
    if (we) begin
      chk({name, ".addr"}, 32'(wpc_addr), 32'(addr));
      chk({name, ".data"}, wpc_data, data);
    end
  endtask

  // driver
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] rdat);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_funct3 = f3; lsu_offset = off; lsu_rdata = rdat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
  endtask

  // reference load: pick bytes by address, then size/sign rules
  task automatic ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdat,
                          output logic [31:0] val, output logic err);
    logic [7:0] b [4];
    int sz;
    bit sgn;
    for (int i = 0; i < 4; i++) b[i] = rdat[8*i +: 8];
    val = '0; err = 1'b0; sz = 0; sgn = 1'b0;
    case (f3)
      3'b000: begin sz = 1; sgn = 1'b1; end
      3'b001: begin sz = 2; sgn = 1'b1; end
      3'b010: sz = 4;
      3'b100: sz = 1;
      3'b101: sz = 2;
      default: sz = 0;
    endcase
    if (sz == 0 || (int'(off) % sz) != 0) begin
      err = 1'b1;
    end else begin
      if (sz == 1) val = {24'd0, b[int'(off)]};
      else if (sz == 2) val = {16'd0, b[int'(off) + 1], b[int'(off)]};
      else val = rdat;
      if (sgn && val[8*sz-1]) val = val | ~((32'd1 << (8*sz)) - 32'd1);
    end
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdat;
    logic        ewe;
    logic        eerr;
    logic [4:0]  eaddr;
    logic [31:0] edata;
  } vec_t;

  vec_t vt [12];

  // random-run state
  logic        a_v, l_v;
  logic [4:0]  a_rd, l_rd;
  logic [31:0] a_data, l_rdata;
  logic [2:0]  l_f3;
  logic [1:0]  l_off;
  logic        m_pend;
  logic [4:0]  m_pend_rd;
  logic [31:0] m_pend_data;
  int          m_losses;
  logic        exp_we, exp_err;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  initial begin
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0,        1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 3'b000, 2'd3, 32'h80FF7F01, 1'b1, 1'b0, 5'd1,  32'hFFFFFF80};
    vt[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 3'b100, 2'd1, 32'h80FF7F01, 1'b1, 1'b0, 5'd2,  32'h0000007F};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 3'b001, 2'd2, 32'h80FF7F01, 1'b1, 1'b0, 5'd3,  32'hFFFF80FF};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 3'b101, 2'd1, 32'h80FF7F01, 1'b0, 1'b1, 5'd0,  32'h0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 3'b010, 2'd0, 32'h80FF7F01, 1'b1, 1'b0, 5'd6,  32'h80FF7F01};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 3'b010, 2'd2, 32'h80FF7F01, 1'b0, 1'b1, 5'd0,  32'h0};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 3'b011, 2'd0, 32'h80FF7F01, 1'b0, 1'b1, 5'd0,  32'h0};
    vt[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 3'b100, 2'd3, 32'h80FF7F01, 1'b1, 1'b0, 5'd9,  32'h00000080};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 3'b101, 2'd0, 32'h80FF7F01, 1'b1, 1'b0, 5'd10, 32'h00007F01};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd11, 3'b000, 2'd0, 32'h80FF7F81, 1'b1, 1'b0, 5'd11, 32'hFFFFFF81};
    vt[11] = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0};

    // reset state
    idle();
    #12;
    chk("rst.we", 32'(wpc_we), 32'd0);
    chk("rst.addr", 32'(wpc_addr), 32'd0);
    chk("rst.data", wpc_data, 32'd0);
    chk("rst.err", 32'(load_err), 32'd0);
    chk("rst.alu_ready", 32'(alu_ready), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("post_rst.alu_ready", 32'(alu_ready), 32'd1);

    // single-beat vectors, applied back to back
    foreach (vt[i]) begin
      drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].f3, vt[i].off, vt[i].rdat);
      #1;
      chk($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'd1);
      chk($sformatf("vec%0d.lsu_ready", i), 32'(lsu_ready), 32'd1);
      step();
      chk_wr($sformatf("vec%0d", i), vt[i].ewe, vt[i].eerr, vt[i].eaddr, vt[i].edata);
      chk($sformatf("vec%0d.alu_ready_after", i), 32'(alu_ready), 32'd1);
    end
    idle();
    step();
    chk_wr("idle", 1'b0, 1'b0, 5'd0, 32'd0);

    // collision: LSU wins first, ALU drains from the skid next cycle
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd4, 3'b010, 2'd0, 32'h12345678);
    step();
    chk_wr("coll.c1", 1'b1, 1'b0, 5'd4, 32'h12345678);
    chk("coll.c1.alu_ready", 32'(alu_ready), 32'd0);
`ifdef JEDRO_1_WB_BYPASS_EN
    chk("coll.byp_skid_valid", 32'(byp_skid_valid), 32'd1);
    chk("coll.byp_skid_addr", 32'(byp_skid_addr), 32'd3);
    chk("coll.byp_skid_data", byp_skid_data, 32'hA5A5A5A5);
    chk("coll.byp_addr", 32'(byp_addr), 32'd4);
    chk("coll.byp_valid", 32'(byp_valid), 32'd1);
`endif
    idle();
    step();
    chk_wr("coll.c2", 1'b1, 1'b0, 5'd3, 32'hA5A5A5A5);
    chk("coll.c2.alu_ready", 32'(alu_ready), 32'd1);
`ifdef JEDRO_1_WB_BYPASS_EN
    chk("coll.byp_skid_drained", 32'(byp_skid_valid), 32'd0);
`endif

    // starvation: LIMIT LSU wins, then the skid entry is forced through
    drive(1'b1, 5'd7, 32'h77777777, 1'b1, 5'd10, 3'b010, 2'd0, 32'h100);
    step();
    chk_wr("starve.l0", 1'b1, 1'b0, 5'd10, 32'h100);
    alu_valid = 1'b0;
    for (int k = 1; k < LIMIT; k++) begin
      lsu_rd = 5'(10 + k); lsu_rdata = 32'(256 + k);
      #1;
      chk($sformatf("starve.l%0d.lsu_ready", k), 32'(lsu_ready), 32'd1);
      step();
      chk_wr($sformatf("starve.l%0d", k), 1'b1, 1'b0, 5'(10 + k), 32'(256 + k));
    end
    lsu_rd = 5'd20; lsu_rdata = 32'h200;
    #1;
    chk("starve.force.lsu_ready", 32'(lsu_ready), 32'd0);
    step();
    chk_wr("starve.force", 1'b1, 1'b0, 5'd7, 32'h77777777);
    chk("starve.force.alu_ready", 32'(alu_ready), 32'd1);
    chk("starve.resume.lsu_ready", 32'(lsu_ready), 32'd1);
    step();
    chk_wr("starve.resume", 1'b1, 1'b0, 5'd20, 32'h200);
    idle();
    step();

    // x0 destination: handshake completes without a write
    drive(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    step();
    chk_wr("x0", 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x0.alu_ready", 32'(alu_ready), 32'd1);
    idle();
    step();

    // reset with the skid occupied
    drive(1'b1, 5'd21, 32'h21212121, 1'b1, 5'd22, 3'b010, 2'd0, 32'h22222222);
    step();
    chk("rstmid.alu_ready_full", 32'(alu_ready), 32'd0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk_wr("rstmid.in_rst", 1'b0, 1'b0, 5'd0, 32'd0);
    chk("rstmid.addr", 32'(wpc_addr), 32'd0);
    chk("rstmid.data", wpc_data, 32'd0);
    chk("rstmid.alu_ready", 32'(alu_ready), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_wr($sformatf("rstmid.after%0d", k), 1'b0, 1'b0, 5'd0, 32'd0);
      chk($sformatf("rstmid.after%0d.alu_ready", k), 32'(alu_ready), 32'd1);
    end

    // randomized run against the reference model
    a_v = 1'b0; l_v = 1'b0; m_pend = 1'b0; m_losses = 0;
    a_rd = '0; a_data = '0; l_rd = '0; l_rdata = '0; l_f3 = '0; l_off = '0;
    m_pend_rd = '0; m_pend_data = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        cand_v, forced, ld_err;
      logic [4:0]  cand_rd;
      logic [31:0] cand_data, ld_val;
      if (!a_v && $urandom_range(0, 2) != 0) begin
        a_v = 1'b1; a_rd = 5'($urandom_range(0, 31)); a_data = $urandom;
      end
      if (!l_v && $urandom_range(0, 3) != 0) begin
        l_v = 1'b1; l_rd = 5'($urandom_range(0, 31)); l_rdata = $urandom;
        l_f3 = 3'($urandom_range(0, 7)); l_off = 2'($urandom_range(0, 3));
      end
      drive(a_v, a_rd, a_data, l_v, l_rd, l_f3, l_off, l_rdata);
      cand_v    = m_pend | a_v;
      cand_rd   = m_pend ? m_pend_rd : a_rd;
      cand_data = m_pend ? m_pend_data : a_data;
      forced    = cand_v && (m_losses == LIMIT);
      #1;
      chk("rand.alu_ready", 32'(alu_ready), 32'(!m_pend));
      chk("rand.lsu_ready", 32'(lsu_ready), 32'(!forced));
      exp_we = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_data = '0;
      if (l_v && !forced) begin
        ref_load(l_f3, l_off, l_rdata, ld_val, ld_err);
        exp_err = ld_err; exp_we = !ld_err && (l_rd != 0);
        exp_addr = l_rd; exp_data = ld_val;
        l_v = 1'b0;
        if (cand_v) begin
          m_losses++;
          if (!m_pend) begin
            m_pend = 1'b1; m_pend_rd = a_rd; m_pend_data = a_data; a_v = 1'b0;
          end
        end
      end else if (cand_v) begin
        exp_we = (cand_rd != 0); exp_addr = cand_rd; exp_data = cand_data;
        if (m_pend) m_pend = 1'b0;
        else a_v = 1'b0;
        m_losses = 0;
      end else begin
        m_losses = 0;
      end
      step();
      chk_wr("rand", exp_we, exp_err, exp_addr, exp_data);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
